// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst front end.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } spi_state_e;

    localparam int SPI_DW    = 8;
    localparam int SPI_DEPTH = 8;

    // Substituted for a response that never arrived, keeping host byte counts aligned.
    localparam logic [SPI_DW-1:0] SPI_TMO_FILL = '1;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Host byte streams plus the spi_master start/done handshake.
// slave = controller view, master = host/spi_master side (the bench).
interface spi_burst_ctrl_if #(
    parameter int DW = 8
);
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          m_start;
    logic [DW-1:0] m_mosi_data;
    logic          m_done;
    logic [DW-1:0] m_miso_data;

    modport slave (
        input  tx_valid, tx_data, rx_ready, m_done, m_miso_data,
        output tx_ready, rx_valid, rx_data, m_start, m_mosi_data
    );

    modport master (
        output tx_valid, tx_data, rx_ready, m_done, m_miso_data,
        input  tx_ready, rx_valid, rx_data, m_start, m_mosi_data
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; push ignored when full, pop ignored when empty.
// Head reads as zero while empty so the output has a defined reset value.
module spi_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                push_dat,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [DW-1:0]                head
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                level <= level + 1'b1;
            end else if (pop_en && !push_en) begin
                level <= level - 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_burst_ctrl.sv
// Streams host TX bytes one at a time into spi_master and queues each reply in an RX FIFO.
// Optional SPI_BURST_TIMEOUT_EN adds a sticky err output and a WAIT_DONE watchdog.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH   = SPI_DEPTH,
    parameter int DW      = SPI_DW,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    spi_burst_ctrl_if.slave             bus,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  tx_level,
    output logic [$clog2(DEPTH+1)-1:0]  rx_level
`ifdef SPI_BURST_TIMEOUT_EN
    ,
    output logic                        err
`endif
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_err
        $error("spi_burst_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    spi_state_e    state;
    spi_state_e    state_nxt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_pop;
    logic [DW-1:0] tx_head;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic [DW-1:0] rx_push_dat;
    logic          tmo_hit;

    spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.tx_valid),
        .push_dat (bus.tx_data),
        .pop      (tx_pop),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level),
        .head     (tx_head)
    );

    spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (rx_push_dat),
        .pop      (bus.rx_ready),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level),
        .head     (bus.rx_data)
    );

    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;
    assign busy         = (state != IDLE) || !tx_empty;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_DONE) && !bus.m_done && (tmo_cnt == TW'(TIMEOUT-1));

    // Held at zero outside WAIT_DONE, so it restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        rx_push_dat = bus.m_miso_data;
        case (state)
            IDLE: begin
                // Only issue when the reply is guaranteed an RX slot.
                if (!tx_empty && !rx_full) begin
                    tx_pop    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.m_done) begin
                    rx_push   = 1'b1;
                    state_nxt = RELEASE;
                end else if (tmo_hit) begin
                    rx_push     = 1'b1;
                    rx_push_dat = DW'(SPI_TMO_FILL);
                    state_nxt   = IDLE;
                end
            end
            RELEASE: begin
                if (!bus.m_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // m_start is registered off START, so the pulse lands one cycle after the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.m_start     <= 1'b0;
            bus.m_mosi_data <= '0;
        end else begin
            state       <= state_nxt;
            bus.m_start <= (state == START);
            if (tx_pop) begin
                bus.m_mosi_data <= tx_head;
            end
        end
    end
endmodule
